// File: rtl/spart_bus_scheduler.sv
// spart_bus_scheduler: programs the SPART baud divisor, then runs RX/TX bus cycles.
// Define SPART_SCHED_RR_EN to alternate RD/WR grants when both are eligible.
module spart_bus_scheduler #(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] baud_sel,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       init_done
);

  typedef enum logic [2:0] {
    INIT_LO,
    INIT_HI,
    IDLE,
    RD,
    WR
  } state_t;

  localparam logic [15:0] DIV_4800  = 16'(CLK_HZ / 76800 - 1);
  localparam logic [15:0] DIV_9600  = 16'(CLK_HZ / 153600 - 1);
  localparam logic [15:0] DIV_19200 = 16'(CLK_HZ / 307200 - 1);
  localparam logic [15:0] DIV_38400 = 16'(CLK_HZ / 614400 - 1);

  state_t      state;
  logic        run;
  logic [1:0]  baud_q;
  logic [15:0] div_live;
  logic [7:0]  div_hi_q;
  logic [7:0]  dout;
  logic        tx_full;
  logic [7:0]  tx_hold;
  logic        rx_full;
  logic        rd_ok;
  logic        wr_ok;
  logic        pick_rd;

  assign tx_ready = !tx_full;
  assign rx_valid = rx_full;
  assign databus  = (iocs && !iorw) ? dout : 8'hzz;

  assign rd_ok = init_done && rda && !rx_full;
  assign wr_ok = init_done && tbr && tx_full;

`ifdef SPART_SCHED_RR_EN
  logic last_wr;
  assign pick_rd = rd_ok && (!wr_ok || last_wr);
`else
  assign pick_rd = rd_ok;
`endif

  // divisor for the live baud selection, taken when an init sequence starts
  always_comb begin
    div_live = DIV_9600;
    unique case (baud_sel)
      2'd0: div_live = DIV_4800;
      2'd1: div_live = DIV_9600;
      2'd2: div_live = DIV_19200;
      2'd3: div_live = DIV_38400;
    endcase
  end

  // bus sequencer: state and registered bus controls advance together
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT_LO;
      run       <= 1'b0;
      init_done <= 1'b0;
      baud_q    <= 2'd0;
      div_hi_q  <= 8'h00;
      dout      <= 8'h00;
      iocs      <= 1'b0;
      iorw      <= 1'b1;
      ioaddr    <= 2'b01;
`ifdef SPART_SCHED_RR_EN
      last_wr   <= 1'b1;
`endif
    end else if (!run) begin
      run      <= 1'b1;
      baud_q   <= baud_sel;
      div_hi_q <= div_live[15:8];
      dout     <= div_live[7:0];
      iocs     <= 1'b1;
      iorw     <= 1'b0;
      ioaddr   <= 2'b10;
    end else begin
      unique case (state)
        INIT_LO: begin
          state  <= INIT_HI;
          dout   <= div_hi_q;
          iocs   <= 1'b1;
          iorw   <= 1'b0;
          ioaddr <= 2'b11;
        end
        INIT_HI: begin
          state     <= IDLE;
          init_done <= 1'b1;
          iocs      <= 1'b0;
          iorw      <= 1'b1;
          ioaddr    <= 2'b01;
        end
        IDLE: begin
          if (baud_sel != baud_q) begin
            state     <= INIT_LO;
            init_done <= 1'b0;
            baud_q    <= baud_sel;
            div_hi_q  <= div_live[15:8];
            dout      <= div_live[7:0];
            iocs      <= 1'b1;
            iorw      <= 1'b0;
            ioaddr    <= 2'b10;
          end else if (pick_rd) begin
            state  <= RD;
            iocs   <= 1'b1;
            iorw   <= 1'b1;
            ioaddr <= 2'b00;
`ifdef SPART_SCHED_RR_EN
            last_wr <= 1'b0;
`endif
          end else if (wr_ok) begin
            state  <= WR;
            dout   <= tx_hold;
            iocs   <= 1'b1;
            iorw   <= 1'b0;
            ioaddr <= 2'b00;
`ifdef SPART_SCHED_RR_EN
            last_wr <= 1'b1;
`endif
          end
        end
        RD, WR: begin
          state  <= IDLE;
          iocs   <= 1'b0;
          iorw   <= 1'b1;
          ioaddr <= 2'b01;
        end
        default: begin
          state  <= IDLE;
          iocs   <= 1'b0;
          iorw   <= 1'b1;
          ioaddr <= 2'b01;
        end
      endcase
    end
  end

  // one-entry TX and RX holding registers around the bus cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_full <= 1'b0;
      tx_hold <= 8'h00;
      rx_full <= 1'b0;
      rx_data <= 8'h00;
    end else begin
      if (tx_valid && tx_ready) begin
        tx_full <= 1'b1;
        tx_hold <= tx_data;
      end else if (state == WR) begin
        tx_full <= 1'b0;
      end
      if (state == RD) begin
        rx_full <= 1'b1;
        rx_data <= databus;
      end else if (rx_valid && rx_ready) begin
        rx_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spart_bus_scheduler.sv
// tb_spart_bus_scheduler: init vectors, directed bus sequences and a
// randomized run against a transaction-level model of the scheduler.
module tb_spart_bus_scheduler;

  logic       clk;
  logic       rst;
  logic [1:0] baud_sel;
  logic       rda;
  logic       tbr;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       init_done;
  logic [7:0] spart_byte;

  int checks;
  int errors;

  spart_bus_scheduler #(.CLK_HZ(50000000)) dut (
    .clk(clk),
    .rst(rst),
    .baud_sel(baud_sel),
    .rda(rda),
    .tbr(tbr),
    .iocs(iocs),
    .iorw(iorw),
    .ioaddr(ioaddr),
    .databus(databus),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .init_done(init_done)
  );

  // SPART side: returns a byte whenever the scheduler reads
  assign databus = (iocs && iorw) ? spart_byte : 8'hzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] lo;
    logic [7:0] hi;
  } init_vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic do_init(input logic [1:0] sel);
    rst = 1'b1;
    baud_sel = sel;
    step();
    rst = 1'b0;
    step();
    step();
    step();
  endtask

  init_vec_t tv[4];
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int op;
  int nxt;
  int last_wr;
  logic rd_el;
  logic wr_el;
  logic rr;

  initial begin
    checks = 0;
    errors = 0;
`ifdef SPART_SCHED_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    tv[0] = '{2'd0, 8'h8A, 8'h02};
    tv[1] = '{2'd2, 8'hA1, 8'h00};
    tv[2] = '{2'd3, 8'h50, 8'h00};
    tv[3] = '{2'd1, 8'h44, 8'h01};
    rst = 1'b1;
    baud_sel = 2'd1;
    rda = 1'b0;
    tbr = 1'b0;
    tx_data = 8'h00;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    spart_byte = 8'h00;

    // reset state and divisor programming for every baud rate
    for (int i = 0; i < 4; i++) begin
      rst = 1'b1;
      baud_sel = tv[i].sel;
      step();
      step();
      chk("rst_iocs", iocs, 0);
      chk("rst_iorw", iorw, 1);
      chk("rst_ioaddr", ioaddr, 2'b01);
      chk("rst_tx_ready", tx_ready, 1);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_init_done", init_done, 0);
      rst = 1'b0;
      step();
      chk("lo_iocs", iocs, 1);
      chk("lo_iorw", iorw, 0);
      chk("lo_ioaddr", ioaddr, 2'b10);
      chk("lo_data", databus, tv[i].lo);
      step();
      chk("hi_ioaddr", ioaddr, 2'b11);
      chk("hi_data", databus, tv[i].hi);
      chk("hi_init_done", init_done, 0);
      step();
      chk("idle_iocs", iocs, 0);
      chk("idle_init_done", init_done, 1);
    end

    // RD, then blocking while the RX register stays full
    rda = 1'b1;
    spart_byte = 8'h3C;
    step();
    chk("rd_iocs", iocs, 1);
    chk("rd_iorw", iorw, 1);
    chk("rd_ioaddr", ioaddr, 2'b00);
    step();
    chk("rd_rx_valid", rx_valid, 1);
    chk("rd_rx_data", rx_data, 8'h3C);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rd_blocked", iocs, 0);
    end
    rx_ready = 1'b1;
    step();
    chk("drain_rx_valid", rx_valid, 0);
    chk("drain_no_rd", iocs, 0);
    rx_ready = 1'b0;
    spart_byte = 8'h5A;
    step();
    chk("rd2_iocs", iocs, 1);
    chk("rd2_iorw", iorw, 1);
    rda = 1'b0;
    step();
    chk("rd2_rx_data", rx_data, 8'h5A);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;

    // WR of a client byte
    tbr = 1'b1;
    tx_valid = 1'b1;
    tx_data = 8'hA5;
    step();
    tx_valid = 1'b0;
    chk("wr_load_ready", tx_ready, 0);
    chk("wr_load_iocs", iocs, 0);
    step();
    chk("wr_iocs", iocs, 1);
    chk("wr_iorw", iorw, 0);
    chk("wr_ioaddr", ioaddr, 2'b00);
    chk("wr_data", databus, 8'hA5);
    chk("wr_ready", tx_ready, 0);
    step();
    chk("wr_done_ready", tx_ready, 1);
    chk("wr_done_iocs", iocs, 0);
    tbr = 1'b0;

    // contention: first grant RD, second depends on arbitration mode
    tx_valid = 1'b1;
    tx_data = 8'h11;
    step();
    tx_valid = 1'b0;
    rda = 1'b1;
    tbr = 1'b1;
    spart_byte = 8'h77;
    step();
    chk("arb1_iocs", iocs, 1);
    chk("arb1_rd", iorw, 1);
    rda = 1'b0;
    tbr = 1'b0;
    step();
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    rda = 1'b1;
    tbr = 1'b1;
    step();
    chk("arb2_iocs", iocs, 1);
    chk("arb2_rd", iorw, !rr);
    rda = 1'b0;
    tbr = 1'b0;
    step();

    // baud change during WR: cycle completes, then reinit, RX byte kept
    do_init(2'd1);
    rda = 1'b1;
    spart_byte = 8'hC3;
    step();
    rda = 1'b0;
    step();
    tx_valid = 1'b1;
    tx_data = 8'h99;
    step();
    tx_valid = 1'b0;
    tbr = 1'b1;
    step();
    chk("bc_wr_iocs", iocs, 1);
    chk("bc_wr_data", databus, 8'h99);
    baud_sel = 2'd3;
    tbr = 1'b0;
    step();
    chk("bc_done_iocs", iocs, 0);
    step();
    chk("bc_lo_addr", ioaddr, 2'b10);
    chk("bc_lo_data", databus, 8'h50);
    chk("bc_lo_init_done", init_done, 0);
    step();
    chk("bc_hi_addr", ioaddr, 2'b11);
    chk("bc_hi_data", databus, 8'h00);
    step();
    chk("bc_init_done", init_done, 1);
    chk("bc_rx_kept", rx_valid, 1);
    chk("bc_rx_data", rx_data, 8'hC3);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;

    // reset during WR abandons the cycle
    tx_valid = 1'b1;
    tx_data = 8'h5E;
    step();
    tx_valid = 1'b0;
    tbr = 1'b1;
    step();
    chk("rw_wr_data", databus, 8'h5E);
    rst = 1'b1;
    step();
    chk("rw_iocs", iocs, 0);
    chk("rw_tx_ready", tx_ready, 1);
    chk("rw_init_done", init_done, 0);
    rst = 1'b0;
    tbr = 1'b0;
    step();
    chk("rw_lo_iocs", iocs, 1);
    chk("rw_lo_addr", ioaddr, 2'b10);
    chk("rw_lo_data", databus, 8'h50);

    // randomized traffic against the transaction model
    do_init(2'd2);
    tx_q.delete();
    rx_q.delete();
    op = 0;
    last_wr = 1;
    for (int k = 0; k < 400; k++) begin
      chk("rnd_iocs", iocs, op != 0);
      if (op == 0) begin
        chk("rnd_idle_iorw", iorw, 1);
        chk("rnd_idle_addr", ioaddr, 2'b01);
      end else begin
        chk("rnd_iorw", iorw, op == 1);
        chk("rnd_addr", ioaddr, 2'b00);
      end
      if (op == 2) chk("rnd_wdata", databus, tx_q[0]);
      chk("rnd_tx_ready", tx_ready, tx_q.size() == 0);
      chk("rnd_rx_valid", rx_valid, rx_q.size() != 0);
      if (rx_q.size() != 0) chk("rnd_rx_data", rx_data, rx_q[0]);
      rda = 1'($urandom_range(0, 1));
      tbr = 1'($urandom_range(0, 1));
      tx_valid = 1'($urandom_range(0, 1));
      tx_data = 8'($urandom);
      rx_ready = ($urandom_range(0, 9) < 4);
      spart_byte = 8'($urandom);
      nxt = 0;
      if (op == 0) begin
        rd_el = rda && (rx_q.size() == 0);
        wr_el = tbr && (tx_q.size() != 0);
        if (rd_el && wr_el) nxt = (rr && last_wr == 0) ? 2 : 1;
        else if (rd_el) nxt = 1;
        else if (wr_el) nxt = 2;
      end
      if (nxt == 1) last_wr = 0;
      if (nxt == 2) last_wr = 1;
      if (op == 2) void'(tx_q.pop_front());
      else if (tx_valid && tx_q.size() == 0) tx_q.push_back(tx_data);
      if (op == 1) rx_q.push_back(spart_byte);
      else if (rx_ready && rx_q.size() != 0) void'(rx_q.pop_front());
      op = nxt;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spart_bus_scheduler.md
SPART_BUS_SCHEDULER -- requirements
Module: spart_bus_scheduler

Interface
REQ-001 Parameter: CLK_HZ, default 50000000, system clock frequency used for divisor computation.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 baud_sel  input  2  0=4800, 1=9600, 2=19200, 3=38400 baud.
REQ-005 rda  input  1  SPART receive data available.
REQ-006 tbr  input  1  SPART transmit buffer ready.
REQ-007 iocs  output  1  SPART chip select; high only during a bus cycle.
REQ-008 iorw  output  1  1=read, 0=write.
REQ-009 ioaddr  output  2  00=TX/RX data, 01=status, 10=divisor low, 11=divisor high.
REQ-010 databus  inout  8  SPART data bus; driven only when iocs=1 and iorw=0, else Z.
REQ-011 tx_data  input  8  client transmit byte.
REQ-012 tx_valid / tx_ready  input / output  1 each  client TX handshake; transfer when both high.
REQ-013 rx_data  output  8  received byte.
REQ-014 rx_valid / rx_ready  output / input  1 each  client RX handshake; transfer when both high.
REQ-015 init_done  output  1  high when divisor programmed and scheduler serving traffic.

Function
REQ-016 States SHALL be INIT_LO, INIT_HI, IDLE, RD, WR; each state other than IDLE is exactly one bus cycle.
REQ-017 Divisor SHALL be CLK_HZ/(16*baud) - 1, integer truncation, 16 bits; at 50 MHz: 650, 324, 161, 80.
REQ-018 INIT_LO: iocs=1, iorw=0, ioaddr=10, databus=divisor[7:0]; next INIT_HI.
REQ-019 INIT_HI: iocs=1, iorw=0, ioaddr=11, databus=divisor[15:8]; next IDLE; init_done set at the following edge.
REQ-020 IDLE: iocs=0, iorw=1, ioaddr=01, databus Z.
REQ-021 TX holding register (1 entry): tx_ready = !tx_full, combinational; handshake loads tx_data and sets tx_full.
REQ-022 RX holding register (1 entry): rx_valid = rx_full; handshake clears rx_full.
REQ-023 RD eligible when init_done && rda && !rx_full; RD: iocs=1, iorw=1, ioaddr=00; databus sampled at end of cycle into rx_data; rx_valid high the next cycle.
REQ-024 WR eligible when init_done && tbr && tx_full; WR: iocs=1, iorw=0, ioaddr=00, databus=held byte; tx_full cleared at end of cycle, so tx_ready is high the next cycle.
REQ-025 RD and WR SHALL return to IDLE; back-to-back operations SHALL have at least one IDLE cycle between them.
REQ-026 baud_sel SHALL be latched at INIT_LO entry; in IDLE, a mismatch with the live baud_sel SHALL clear init_done and enter INIT_LO, with priority over RD and WR.
REQ-027 A baud_sel change during RD or WR SHALL let the cycle complete, then reinitialise; TX and RX holding contents are preserved.
REQ-028 A full RX register SHALL block RD; rda is ignored (no overwrite, no drop) until the client drains it.
REQ-029 Simultaneous RX drain and RD eligibility SHALL not issue RD in the same cycle; RD is issued on the next IDLE evaluation.

Reset
REQ-030 On rst: state=INIT_LO, tx_full=0, rx_full=0, init_done=0, rx_data=0, arbitration pointer=WR.
REQ-031 During rst: iocs=0, iorw=1, ioaddr=01, databus Z, tx_ready=1, rx_valid=0.
REQ-032 rst asserted mid-operation SHALL abandon the bus cycle at that edge and discard held bytes.
REQ-033 INIT_LO SHALL be entered on the first edge after rst deasserts.

Configuration
REQ-034 Macro SPART_SCHED_RR_EN undefined: when both RD and WR are eligible in IDLE, RD always wins.
REQ-035 Macro SPART_SCHED_RR_EN defined: when both are eligible, grant alternates, favouring the opposite of the last granted op; pointer reset=WR (first grant RD).

Verification
REQ-036 Reset, baud_sel=1, CLK_HZ=50e6 -> cycle 1: write ioaddr=10 data 0x44; cycle 2: write ioaddr=11 data 0x01; init_done=1 at cycle 3.
REQ-037 tx_valid with 0xA5, tbr=1 -> one WR cycle, ioaddr=00, databus=0xA5; tx_ready low for exactly that interval, then high.
REQ-038 rda=1, SPART drives 0x3C -> RD cycle; rx_valid=1 with rx_data=0x3C; rda held with rx_ready=0 -> no second RD until drained.
REQ-039 rda=1 and tx_full/tbr=1 together for 4 ops -> macro undefined: RD first every contention; SPART_SCHED_RR_EN defined: grants RD, WR, RD, WR.
REQ-040 baud_sel 1->3 during WR -> WR completes, init_done drops, writes 0x50 to ioaddr=10 and 0x00 to ioaddr=11, init_done rises.
REQ-041 rst asserted during WR -> next cycle iocs=0, databus Z, tx_ready=1, then INIT_LO sequence.
